// File: rtl/sys_ctrl_rx.sv
// Receive-side command decoder: turns framed UART bytes into register-file
// write/read strobes and ALU start/clock-gate control. All outputs registered.
module sys_ctrl_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  OUT_Valid,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  CLK_EN
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_ADDR   = 3'd1;
    localparam logic [2:0] WR_DATA   = 3'd2;
    localparam logic [2:0] RD_ADDR   = 3'd3;
    localparam logic [2:0] ALU_OPA   = 3'd4;
    localparam logic [2:0] ALU_OPB   = 3'd5;
    localparam logic [2:0] ALU_FUN_S = 3'd6;
    localparam logic [2:0] ALU_WAIT  = 3'd7;

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

    // Operands A and B always land in the first two register-file slots.
    localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(1);

    logic [2:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic                  wr_en_q,   wr_en_d;
    logic                  rd_en_q,   rd_en_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  alu_en_q,  alu_en_d;
    logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
    logic                  clk_en_q,  clk_en_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        clk_en_d  = 1'b0;
        address_d = address_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_DATA == CMD_RD) begin
                        state_d = RD_ADDR;
                    end else if (RX_P_DATA == CMD_ALU_OP) begin
                        state_d = ALU_OPA;
                    end else if (RX_P_DATA == CMD_ALU_NO) begin
                        state_d = ALU_FUN_S;
                    end
                end
            end

            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = WR_DATA;
                end
            end

            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_q;
                    wr_data_d = RX_P_DATA;
                    state_d   = IDLE;
                end
            end

            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_en_d   = 1'b1;
                    address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = IDLE;
                end
            end

            ALU_OPA: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = OPA_ADDR;
                    wr_data_d = RX_P_DATA;
                    state_d   = ALU_OPB;
                end
            end

            ALU_OPB: begin
                if (RX_D_VLD) begin
                    wr_en_d   = 1'b1;
                    address_d = OPB_ADDR;
                    wr_data_d = RX_P_DATA;
                    state_d   = ALU_FUN_S;
                end
            end

            ALU_FUN_S: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    clk_en_d  = 1'b1;
                    state_d   = ALU_WAIT;
                end
            end

            ALU_WAIT: begin
                // Received bytes are dropped here; only the ALU result releases the gate.
                if (OUT_Valid) begin
                    state_d = IDLE;
                end else begin
                    clk_en_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            clk_en_q  <= 1'b0;
            address_q <= '0;
            wr_data_q <= '0;
            alu_fun_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            clk_en_q  <= clk_en_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
            alu_fun_q <= alu_fun_d;
        end
    end

    assign WrEn    = wr_en_q;
    assign RdEn    = rd_en_q;
    assign ALU_EN  = alu_en_q;
    assign CLK_EN  = clk_en_q;
    assign Address = address_q;
    assign WrData  = wr_data_q;
    assign ALU_FUN = alu_fun_q;

endmodule

// File: doc/sys_ctrl_rx.md
Name: sys_ctrl_rx

Overview:
Command decoder sitting between the UART receiver and the register file/ALU. It consumes one synchronized byte per RX_D_VLD pulse, parses 2- to 4-byte command frames, and issues register-file write/read strobes and ALU operations with ALU clock-gate control. Its results (RdDATA/RdDATA_VLD from the register file, ALU_OUT/OUT_Valid from the ALU) feed the transmit-side controller.

Parameters:
DATA_WIDTH, 8, width of received bytes and register-file data
ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
FUN_WIDTH, 4, ALU function code width; taken from the low bits of the function byte

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-low
RX_P_DATA  input  DATA_WIDTH  received byte, valid only while RX_D_VLD=1
RX_D_VLD  input  1  one-cycle pulse per received byte
OUT_Valid  input  1  ALU result valid
WrEn  output  1  register-file write strobe, one cycle
RdEn  output  1  register-file read strobe, one cycle
Address  output  ADDR_WIDTH  register-file address
WrData  output  DATA_WIDTH  register-file write data
ALU_EN  output  1  ALU start strobe, one cycle
ALU_FUN  output  FUN_WIDTH  ALU function code
CLK_EN  output  1  ALU clock-gate enable

Behaviour:
- All outputs are registered. Reset value of every output is 0. FSM resets to IDLE.
- Each output strobe (WrEn, RdEn, ALU_EN) is high for exactly the one cycle after the RX_D_VLD cycle that completes its field.
- Address, WrData and ALU_FUN hold their last value between strobes.
- Command bytes are recognised only in IDLE:
  - 0xAA: register write.
  - 0xBB: register read.
  - 0xCC: ALU operation with operands.
  - 0xDD: ALU operation without operands.
  - Any other byte in IDLE is ignored; the FSM stays in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUN_S, ALU_WAIT. All transitions happen only on RX_D_VLD=1, except exits from ALU_WAIT.
- IDLE transitions: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; 0xCC -> ALU_OPA; 0xDD -> ALU_FUN_S.
- WR_ADDR: latch byte[ADDR_WIDTH-1:0] into the internal address register -> WR_DATA.
- WR_DATA: WrEn=1, Address=latched address, WrData=byte -> IDLE.
- RD_ADDR: RdEn=1, Address=byte[ADDR_WIDTH-1:0] -> IDLE.
- ALU_OPA: WrEn=1, Address=0, WrData=byte -> ALU_OPB.
- ALU_OPB: WrEn=1, Address=1, WrData=byte -> ALU_FUN_S.
- ALU_FUN_S: ALU_FUN=byte[FUN_WIDTH-1:0], ALU_EN=1, CLK_EN=1 -> ALU_WAIT.
- ALU_WAIT: CLK_EN stays 1. When OUT_Valid=1 -> IDLE, and CLK_EN=0 from the following cycle.
- CLK_EN is 0 in every state other than ALU_WAIT and the ALU_EN cycle.
- Mid-frame bytes are data, never commands. Example: 0xAA received in WR_DATA is written as data.
- RX_D_VLD during ALU_WAIT: byte dropped, no state change.
- OUT_Valid outside ALU_WAIT is ignored.
- RX_D_VLD asserted on consecutive cycles: each pulse is a separate byte, consumed in order. No back-pressure; the FSM accepts one byte per cycle.
- There is no inter-byte timeout; a partial frame waits indefinitely.
- Reset asserted mid-frame: FSM returns to IDLE, strobes and CLK_EN drop immediately (async), and the internal address register clears to 0.

Test Plan:
- Write: RX bytes 0xAA, 0x05, 0x3C -> exactly one WrEn pulse with Address=5, WrData=0x3C, one cycle after the third RX_D_VLD. RdEn and ALU_EN stay 0.
- Read: 0xBB, 0x07 -> one RdEn pulse with Address=7. WrEn stays 0. FSM back in IDLE.
- ALU with operands: 0xCC, 0x0A, 0x03, 0x00 -> WrEn at Address=0 with 0x0A, then Address=1 with 0x03. ALU_EN pulse with ALU_FUN=0. CLK_EN high until OUT_Valid is driven 5 cycles later, low on the cycle after.
- ALU without operands plus dropped byte: 0xDD, 0x02, then 0x55 sent during ALU_WAIT -> no WrEn, ALU_FUN=2, ALU_EN one pulse. 0x55 ignored. After OUT_Valid, the next 0xBB,0x01 produces RdEn with Address=1.
- Unknown and in-frame command bytes: 0x11 in IDLE -> no strobes. Then 0xAA, 0x02, 0xAA -> WrEn with Address=2, WrData=0xAA.
- Reset mid-frame: 0xAA, 0x04, assert RST for 2 cycles, release, then 0x3C -> no WrEn and all outputs 0. 0x3C treated as an unknown command. A following 0xBB,0x04 yields RdEn with Address=4.
